// File: rtl/fmap_stream_reader.sv
// Read-side sequencer for the output feature-map buffer: scans the read bank
// channel-major and emits the elements as a valid/ready stream.
module fmap_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_H      = 64,
    parameter int OUT_W      = 64,
    parameter int OUT_C      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  buf_read_en,
    output logic [3:0]            buf_read_ch,
    output logic [5:0]            buf_read_h,
    output logic [5:0]            buf_read_w,
    input  logic [DATA_WIDTH-1:0] buf_data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_ch_last,
    output logic                  m_last
);

    localparam logic [3:0] C_MAX = 4'(OUT_C - 1);
    localparam logic [5:0] H_MAX = 6'(OUT_H - 1);
    localparam logic [5:0] W_MAX = 6'(OUT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [3:0] c_q;
    logic [5:0] h_q;
    logic [5:0] w_q;

    logic                  inflight_q;
    logic                  inf_chl_q;
    logic                  inf_last_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [1:0]            fifo_chl_q;
    logic [1:0]            fifo_last_q;
    logic [1:0]            count_q;
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;

    logic       pop;
    logic       issue;
    logic       accept;
    logic [2:0] credit;
    logic       w_max;
    logic       h_max;
    logic       tag_chl;
    logic       tag_last;

    assign m_valid   = (count_q != 2'd0);
    assign m_data    = fifo_data_q[rd_ptr_q];
    assign m_ch_last = fifo_chl_q[rd_ptr_q];
    assign m_last    = fifo_last_q[rd_ptr_q];
    assign pop       = m_valid && m_ready;

    assign w_max    = (w_q == W_MAX);
    assign h_max    = (h_q == H_MAX);
    assign tag_chl  = w_max && h_max;
    assign tag_last = tag_chl && (c_q == C_MAX);

    // Occupancy counts words already queued plus the one still in the buffer pipe.
    assign credit = {1'b0, count_q} + {2'b00, inflight_q};
    assign issue  = (state_q == RUN) &&
                    ((credit <= 3'd1) || ((credit == 3'd2) && pop));

    // A start coinciding with done is dropped.
    assign accept = (state_q == IDLE) && start && !done_q;

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign buf_read_en = issue;
    assign buf_read_ch = c_q;
    assign buf_read_h  = h_q;
    assign buf_read_w  = w_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (issue && tag_last) state_d = DRAIN;
            DRAIN:   if (pop && m_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == DRAIN) && pop && m_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            c_q <= '0;
            h_q <= '0;
            w_q <= '0;
        end else if (accept) begin
            c_q <= '0;
            h_q <= '0;
            w_q <= '0;
        end else if (issue && !tag_last) begin
            unique case (1'b1)
                !w_max: w_q <= w_q + 6'd1;
                w_max && !h_max: begin
                    w_q <= '0;
                    h_q <= h_q + 6'd1;
                end
                w_max && h_max: begin
                    w_q <= '0;
                    h_q <= '0;
                    c_q <= c_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Tags travel beside the read so the FIFO entry is self-describing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            inf_chl_q  <= 1'b0;
            inf_last_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            inf_chl_q  <= tag_chl;
            inf_last_q <= tag_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) fifo_data_q[i] <= '0;
            fifo_chl_q  <= '0;
            fifo_last_q <= '0;
            count_q     <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
        end else begin
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= buf_data_out;
                fifo_chl_q[wr_ptr_q]  <= inf_chl_q;
                fifo_last_q[wr_ptr_q] <= inf_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(inflight_q) - 2'(pop);
        end
    end

endmodule
